spi_ram: RTL
============

# spi_ram

Command-decoding single-port RAM directly downstream of the SPI slave. Consumes the slave's 10-bit `rx_data`/`rx_valid` words, interprets bits [9:8] as a command (write address, write data, read address, read data), and returns read data to the slave on `dout`/`tx_valid` for serialisation onto MISO. One command executes per SPI frame.

## Interface
- `MEM_DEPTH`, 256: number of 8-bit words; must equal 2**ADDR_SIZE.
- `ADDR_SIZE`, 8: address width; 1..8.
- `TX_HOLD`, 9: cycles `tx_valid` stays high per read (8 bits + load).

- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `din`  in  10  command word from the SPI slave's `rx_data`.
- `rx_valid`  in  1  SPI slave `rx_valid`; level, held high until the frame ends.
- `dout`  out  8  read data to the slave's `tx_data`.
- `tx_valid`  out  1  `dout` valid; to the slave's `tx_valid`.
- `cmd_err`  out  1  one-cycle pulse on an illegal command.

## Operation
- Edge detect: `rx_prev` registers `rx_valid`; a command executes only on a cycle with `rx_valid`=1 and `rx_prev`=0. A held-high `rx_valid` never re-executes.
- Internal state: `wr_addr`, `rd_addr` (ADDR_SIZE), `wr_ok`, `rd_ok` flags, hold counter, FSM.
- Address = `din[ADDR_SIZE-1:0]`; `din[7:ADDR_SIZE]` ignored.
- `din[9:8]`=00: `wr_addr` <= address, `wr_ok` <= 1.
- 01: if `wr_ok`: `mem[wr_addr]` <= `din[7:0]`; else `cmd_err` pulse, no write.
- 10: `rd_addr` <= address, `rd_ok` <= 1.
- 11: if `rd_ok`: `dout` <= `mem[rd_addr]`, start SEND, `rd_ok` <= 0; else `cmd_err` pulse, `dout`/`tx_valid` unchanged.
- FSM: IDLE -> SEND on an accepted 11. SEND: `tx_valid`=1, counter counts TX_HOLD-1 down to 0; SEND -> IDLE when 0. `dout` stable throughout SEND.
- Accepted 11 while in SEND: `dout` reloaded, counter restarts at TX_HOLD-1; `tx_valid` stays high, no gap.
- 00/01/10 during SEND execute normally; SEND unaffected.
- Write then read of the same address returns the new data.
- Memory contents are not reset.

## Timing
- Reset (async, immediate): `dout`=0, `tx_valid`=0, `cmd_err`=0, `rx_prev`=0, `wr_ok`=`rd_ok`=0, addresses 0, FSM IDLE. Reset mid-SEND drops `tx_valid` the same instant.
- Command executes at the first rising edge where `rx_valid`=1 (edge cycle E).
- Write: memory updated at edge E; readable by a read command at any later edge.
- Read: `dout` and `tx_valid` change at edge E; `tx_valid` high for exactly TX_HOLD cycles (E .. E+TX_HOLD-1 edges inclusive; low after edge E+TX_HOLD).
- `cmd_err` high for exactly the one cycle following edge E.
- `rx_valid` falling has no effect. `rx_valid` re-rising the cycle after falling is a new command.

## Configuration
- `SPI_RAM_AUTOINC_EN` defined: after each accepted 01, `wr_addr` <= `wr_addr`+1 mod MEM_DEPTH. After each accepted 11, `rd_addr` <= `rd_addr`+1 mod MEM_DEPTH and `rd_ok` stays 1, so consecutive 11s burst-read.
- Undefined: addresses change only via 00/10; `rd_ok` clears after each read, and a repeated 11 without a new 10 raises `cmd_err`.

## Test plan
- Reset, then `din`=10'h3_00 edge -> `cmd_err` 1 cycle, `tx_valid` stays 0; `din`=10'h1_55 edge -> `cmd_err`, no write.
- 10'h0_12, 10'h1_A5, 10'h2_12, 10'h3_00 (each its own `rx_valid` pulse) -> `dout`=8'hA5, `tx_valid` high exactly 9 cycles.
- `rx_valid` held high 20 cycles with `din`=10'h1_77 after address 12 set -> exactly one write; read of 12 returns 8'h77.
- Read in progress, second 11 after a new 10 to an address holding 8'h3C on hold cycle 4 -> `dout`=8'h3C, `tx_valid` continuous, 9 more cycles.
- `rst_n` low at hold cycle 3 -> `tx_valid`, `dout` 0 immediately; subsequent 11 without 10 -> `cmd_err`.
- `SPI_RAM_AUTOINC_EN`: 10'h0_FF, writes 11, 22 -> `mem[FF]`=11, `mem[00]`=22; 10'h2_FF, two 11s -> `dout` 11 then 22, no `cmd_err`.

Source files
------------

// File: rtl/spi_ram.sv
// rtl/spi_ram.sv - command-decoding RAM behind the SPI slave; optional SPI_RAM_AUTOINC_EN burst addressing
// Executes one 2-bit-opcode command per rx_valid rising edge and holds tx_valid for TX_HOLD cycles per read.
module spi_ram #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int TX_HOLD   = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid,
  output logic       cmd_err
);

  localparam int CNT_W = $clog2(TX_HOLD + 1);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  logic                 r_rx_prev;
  logic [ADDR_SIZE-1:0] r_wr_addr;
  logic [ADDR_SIZE-1:0] r_rd_addr;
  logic                 r_wr_ok;
  logic                 r_rd_ok;
  logic [7:0]           r_dout;
  logic                 r_cmd_err;
  logic [7:0]           r_mem [MEM_DEPTH];
  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;

  logic                 w_edge;
  logic [1:0]           w_cmd;
  logic [ADDR_SIZE-1:0] w_addr;
  logic                 w_wr_go;
  logic                 w_rd_go;
  logic                 w_err;

  // A level-held rx_valid must only trigger once per frame.
  assign w_edge  = rx_valid & ~r_rx_prev;
  assign w_cmd   = din[9:8];
  assign w_addr  = din[ADDR_SIZE-1:0];
  assign w_wr_go = w_edge & (w_cmd == 2'b01) & r_wr_ok;
  assign w_rd_go = w_edge & (w_cmd == 2'b11) & r_rd_ok;
  assign w_err   = w_edge & (((w_cmd == 2'b01) & ~r_wr_ok) | ((w_cmd == 2'b11) & ~r_rd_ok));

  assign dout     = r_dout;
  assign cmd_err  = r_cmd_err;
  assign tx_valid = (r_state == S_SEND);

  always_ff @(posedge clk) begin
    if (w_wr_go) begin
      r_mem[r_wr_addr] <= din[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_prev <= 1'b0;
      r_wr_addr <= '0;
      r_rd_addr <= '0;
      r_wr_ok   <= 1'b0;
      r_rd_ok   <= 1'b0;
      r_dout    <= 8'h00;
      r_cmd_err <= 1'b0;
    end else begin
      r_rx_prev <= rx_valid;
      r_cmd_err <= w_err;
      if (w_edge && (w_cmd == 2'b00)) begin
        r_wr_addr <= w_addr;
        r_wr_ok   <= 1'b1;
      end
      if (w_edge && (w_cmd == 2'b10)) begin
        r_rd_addr <= w_addr;
        r_rd_ok   <= 1'b1;
      end
`ifdef SPI_RAM_AUTOINC_EN
      if (w_wr_go) begin
        r_wr_addr <= r_wr_addr + 1'b1;
      end
      if (w_rd_go) begin
        r_dout    <= r_mem[r_rd_addr];
        r_rd_addr <= r_rd_addr + 1'b1;
      end
`else
      if (w_rd_go) begin
        r_dout  <= r_mem[r_rd_addr];
        r_rd_ok <= 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A read accepted mid-SEND restarts the hold window without dropping tx_valid.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_rd_go) begin
          w_state_nxt = S_SEND;
          w_cnt_nxt   = CNT_W'(TX_HOLD - 1);
        end
      end
      S_SEND: begin
        if (w_rd_go) begin
          w_cnt_nxt = CNT_W'(TX_HOLD - 1);
        end else if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

endmodule
